sel_rr_arbiter: RTL and testbench
=================================

# sel_rr_arbiter

Round-robin arbiter that shares the 4-to-1 signal selector (sel_4to1) among four requesters. Each requester raises a request line and holds it for as long as it needs the selector. The arbiter grants one requester at a time and drives the selector's 2-bit select input. It also enforces a maximum hold time and inserts one idle cycle between owners so the selector output settles before the next owner sees it.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; fixed to 4 to match the selector data width.
- SEL_W, 2: select width, equal to log2(NUM_REQ).
- MAX_HOLD, 16: maximum consecutive cycles a grant may be held; must be at least 2.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Req  in  NUM_REQ  per-requester request, level-sensitive; held high while the requester uses the selector.
- Gnt  out  NUM_REQ  one-hot grant, registered; all zero when no owner.
- S  out  SEL_W  select to sel_4to1, registered; index of the current or most recent owner.
- Valid  out  1  high while a grant is active; equals the OR of Gnt.
- Timeout  out  1  one-cycle pulse when a grant is revoked because MAX_HOLD was reached.

## Operation
- State machine has three states: IDLE, GRANT, GAP. Reset state is IDLE.
- Reset values: Gnt=0, S=0, Valid=0, Timeout=0, hold counter=0, last-owner pointer Last=NUM_REQ-1 (requester 0 wins first).
- IDLE:
  - If Req is non-zero, choose the winner by searching Last+1, Last+2, Last+3, Last (mod 4); the first requester with Req set wins.
  - Load Gnt (one-hot winner), S=winner, Last=winner, counter=0, and go to GRANT.
  - If Req is zero, stay in IDLE; S holds its value.
- GRANT:
  - The counter increments each cycle.
  - If Req[owner]=0, clear Gnt and go to GAP with no Timeout.
  - Else if the counter equals MAX_HOLD-1, clear Gnt, pulse Timeout on the same edge, and go to GAP.
  - Requests from other requesters have no effect in this state; there is no preemption except timeout.
- GAP: exactly one cycle with Gnt=0 and Valid=0, then go to IDLE.
- A requester revoked by timeout stays eligible. Because Last already points at it, it has the lowest priority in the next arbitration.
- Req bits not owned and not yet granted may toggle freely; only their value in IDLE matters.
- Requests are never dropped: a request held high is granted within 3 full ownership periods plus gaps.
- Counter width is clog2(MAX_HOLD). The counter is cleared on every grant and never wraps within a grant.

## Timing
- Grant latency: if Req is sampled at edge n while in IDLE, Gnt and S are valid after edge n. They become visible to sel_4to1 one cycle after the request.
- Release: if Req[owner] drops before edge n, Gnt clears after edge n. The next grant appears after edge n+2 (GAP at n+1, arbitration at n+2).
- Maximum continuous ownership is MAX_HOLD cycles of Gnt high. Timeout is high for exactly one cycle, aligned with the first Gnt=0 cycle.
- Back-to-back owners are separated by a minimum of 2 cycles with Gnt=0 (GAP, then IDLE arbitration).
- If Req[owner] drops in the same cycle the counter reaches MAX_HOLD-1, the release takes priority and Timeout stays 0.
- Reset mid-grant: Rst has priority over all transitions. Gnt clears, S=0, Last=3, and Timeout=0 on the next edge.

## Structure
- Shared package sel_pkg:
  - NUM_REQ and SEL_W constants.
  - state enum typedef (IDLE, GRANT, GAP).
  - function rr_pick(req, last) returning the winner index.
- One natural sub-module: sel_rr_pick, the combinational rotate-and-priority encoder. Its inputs are Req and Last; its outputs are the winner index and an any-request flag.
- Top-level sel_rr_arbiter contains the FSM, hold counter and output registers. The system top instantiates it alongside sel_4to1 with S connected directly.

## Test plan
- Reset: Rst held for 2 cycles with Req=4'b1111 -> Gnt=0, S=0, Valid=0 throughout; after release, the first grant is Gnt=4'b0001, S=0.
- Single requester: Req=4'b0100 for 5 cycles, then 0 -> Gnt=4'b0100 and S=2 for 5 cycles, one GAP cycle, then IDLE; Timeout stays 0.
- Fairness: Req=4'b1111 held, each owner drops its Req for one cycle after 3 cycles of ownership -> grant order 0,1,2,3,0 with a 2-cycle Gnt=0 gap between owners.
- Timeout: MAX_HOLD=16, Req=4'b0010 held constant -> Gnt=4'b0010 for 16 cycles, Timeout pulses once, GAP, then requester 1 is re-granted. With Req=4'b1010 instead, requester 3 is granted next.
- Simultaneous release and timeout: Req[owner] drops on cycle 15 of the grant -> Gnt clears, Timeout=0.
- Reset mid-operation: Rst asserted on cycle 4 of requester 2's grant -> all outputs are at reset values on the next edge, and requester 0 wins the next arbitration.

Source files
------------

// File: rtl/sel_pkg.sv
// rtl/sel_pkg.sv - shared constants, FSM state type and round-robin pick function
//
// Purpose: common definitions for the selector arbiter and its pick encoder.
//   NUM_REQ : number of requesters sharing the 4-to-1 selector
//   SEL_W   : select width, log2(NUM_REQ)
//   state_t : arbiter FSM states (IDLE, GRANT, GAP)
//   rr_pick : winner index searching last+1, last+2, ..., last (mod NUM_REQ)
package sel_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Walk candidates from farthest (last itself) to nearest (last+1) and let
  // each hit overwrite the result, so the nearest requester after last wins.
  // Returns last when req is empty; callers qualify with an any-request flag.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0] idx;
    rr_pick = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last + SEL_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/sel_rr_pick.sv
// rtl/sel_rr_pick.sv - combinational rotate-and-priority encoder for the arbiter
//
// Purpose: selects the next owner in round-robin order after the last owner.
// Ports:
//   req  in  NUM_REQ  request vector
//   last in  SEL_W    index of the most recent owner (lowest priority)
//   win  out SEL_W    winning requester index (meaningful only when any=1)
//   any  out 1        at least one request is present
module sel_rr_pick
  import sel_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   win,
  output logic               any
);

  always_comb begin
    win = rr_pick(req, last);
    any = |req;
  end

endmodule

// File: rtl/sel_rr_arbiter.sv
// rtl/sel_rr_arbiter.sv - round-robin owner arbiter for the shared 4-to-1 selector
//
// Purpose: grants one requester at a time, drives the selector select, limits
// hold time to MAX_HOLD cycles and leaves an idle GAP cycle between owners.
// Ports:
//   Clk     in  1        system clock, rising edge
//   Rst     in  1        synchronous active-high reset
//   Req     in  NUM_REQ  level-sensitive requests
//   Gnt     out NUM_REQ  registered one-hot grant, zero when no owner
//   S       out SEL_W    registered select, current or most recent owner
//   Valid   out 1        registered, high while a grant is active
//   Timeout out 1        one-cycle pulse when a grant is revoked at MAX_HOLD
module sel_rr_arbiter
  import sel_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_REQ-1:0] Req,
  output logic [NUM_REQ-1:0] Gnt,
  output logic [SEL_W-1:0]   S,
  output logic               Valid,
  output logic               Timeout
);

  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SEL_W-1:0]   last;
  logic [SEL_W-1:0]   win;
  logic               any;

  sel_rr_pick u_pick (
    .req  (Req),
    .last (last),
    .win  (win),
    .any  (any)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      Gnt     <= '0;
      S       <= '0;
      Valid   <= 1'b0;
      Timeout <= 1'b0;
      cnt     <= '0;
      last    <= SEL_W'(NUM_REQ - 1);
    end else begin
      Timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            Gnt   <= ONE_HOT0 << win;
            S     <= win;
            last  <= win;
            Valid <= 1'b1;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          // A voluntary release outranks the hold limit, so a requester that
          // lets go on its final allowed cycle is never flagged as timed out.
          if (!Req[S]) begin
            Gnt   <= '0;
            Valid <= 1'b0;
            state <= GAP;
          end else if (cnt == HOLD_LAST) begin
            Gnt     <= '0;
            Valid   <= 1'b0;
            Timeout <= 1'b1;
            state   <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// tb/tb_sel_rr_arbiter.sv - directed self-checking bench for sel_rr_arbiter
module tb_sel_rr_arbiter;

  logic       Clk;
  logic       Rst;
  logic [3:0] Req;
  logic [3:0] Gnt;
  logic [1:0] S;
  logic       Valid;
  logic       Timeout;

  int total;
  int passed;

  sel_rr_arbiter #(.MAX_HOLD(16)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Req     (Req),
    .Gnt     (Gnt),
    .S       (S),
    .Valid   (Valid),
    .Timeout (Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    Req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (Gnt !== 4'b0000) $display("FAIL reset_gnt cyc%0d got %b want 0000", i, Gnt);
      else passed++;
      total++;
      if (S !== 2'd0) $display("FAIL reset_s cyc%0d got %0d want 0", i, S);
      else passed++;
      total++;
      if (Valid !== 1'b0 || Timeout !== 1'b0)
        $display("FAIL reset_valid_timeout cyc%0d got %b%b want 00", i, Valid, Timeout);
      else passed++;
    end
    Rst = 1'b0;
    step();
    total++;
    if (Gnt !== 4'b0001 || S !== 2'd0 || Valid !== 1'b1)
      $display("FAIL reset_first_grant got gnt=%b s=%0d v=%b want gnt=0001 s=0 v=1", Gnt, S, Valid);
    else passed++;
    Req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_single();
    Req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (Gnt !== 4'b0100 || S !== 2'd2 || Timeout !== 1'b0)
        $display("FAIL single_hold cyc%0d got gnt=%b s=%0d to=%b want gnt=0100 s=2 to=0", i, Gnt, S, Timeout);
      else passed++;
    end
    Req = 4'b0000;
    step();
    total++;
    if (Gnt !== 4'b0000 || Valid !== 1'b0 || Timeout !== 1'b0)
      $display("FAIL single_gap got gnt=%b v=%b to=%b want 0000 0 0", Gnt, Valid, Timeout);
    else passed++;
    step();
    total++;
    if (Gnt !== 4'b0000 || S !== 2'd2)
      $display("FAIL single_idle got gnt=%b s=%0d want gnt=0000 s=2", Gnt, S);
    else passed++;
  endtask

  task automatic test_fairness();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp;
    Rst = 1'b1;
    Req = 4'b0000;
    step();
    Rst = 1'b0;
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << order[k];
      step();
      total++;
      if (Gnt !== exp || S !== 2'(order[k]))
        $display("FAIL fair_grant%0d got gnt=%b s=%0d want gnt=%b s=%0d", k, Gnt, S, exp, order[k]);
      else passed++;
      step();
      step();
      total++;
      if (Gnt !== exp)
        $display("FAIL fair_held%0d got %b want %b", k, Gnt, exp);
      else passed++;
      Req[order[k]] = 1'b0;
      step();
      total++;
      if (Gnt !== 4'b0000 || Timeout !== 1'b0)
        $display("FAIL fair_gap%0d got gnt=%b to=%b want 0000 0", k, Gnt, Timeout);
      else passed++;
      Req = 4'b1111;
      step();
      total++;
      if (Gnt !== 4'b0000 || Valid !== 1'b0)
        $display("FAIL fair_idle%0d got gnt=%b v=%b want 0000 0", k, Gnt, Valid);
      else passed++;
    end
    Req = 4'b0000;
  endtask

  task automatic test_timeout();
    int early;
    Req = 4'b0010;
    for (int pass = 0; pass < 2; pass++) begin
      step();
      total++;
      if (Gnt !== 4'b0010 || S !== 2'd1)
        $display("FAIL to_grant%0d got gnt=%b s=%0d want 0010 1", pass, Gnt, S);
      else passed++;
      if (pass == 1) Req = 4'b1010;
      early = 0;
      for (int i = 0; i < 15; i++) begin
        step();
        if (Gnt !== 4'b0010 || Timeout !== 1'b0) early++;
      end
      total++;
      if (early != 0)
        $display("FAIL to_hold%0d got %0d bad cycles want 0", pass, early);
      else passed++;
      step();
      total++;
      if (Gnt !== 4'b0000 || Timeout !== 1'b1 || Valid !== 1'b0)
        $display("FAIL to_pulse%0d got gnt=%b to=%b v=%b want 0000 1 0", pass, Gnt, Timeout, Valid);
      else passed++;
      step();
      total++;
      if (Gnt !== 4'b0000 || Timeout !== 1'b0)
        $display("FAIL to_idle%0d got gnt=%b to=%b want 0000 0", pass, Gnt, Timeout);
      else passed++;
    end
    step();
    total++;
    if (Gnt !== 4'b1000 || S !== 2'd3)
      $display("FAIL to_next_owner got gnt=%b s=%0d want 1000 3", Gnt, S);
    else passed++;
    Req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_release_timeout();
    Req = 4'b0001;
    step();
    total++;
    if (Gnt !== 4'b0001)
      $display("FAIL rel_grant got %b want 0001", Gnt);
    else passed++;
    for (int i = 0; i < 15; i++) step();
    total++;
    if (Gnt !== 4'b0001)
      $display("FAIL rel_last_cycle got %b want 0001", Gnt);
    else passed++;
    Req = 4'b0000;
    step();
    total++;
    if (Gnt !== 4'b0000 || Timeout !== 1'b0 || Valid !== 1'b0)
      $display("FAIL rel_priority got gnt=%b to=%b v=%b want 0000 0 0", Gnt, Timeout, Valid);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    Req = 4'b0100;
    step();
    total++;
    if (Gnt !== 4'b0100)
      $display("FAIL mid_grant got %b want 0100", Gnt);
    else passed++;
    step();
    step();
    step();
    Rst = 1'b1;
    step();
    total++;
    if (Gnt !== 4'b0000 || S !== 2'd0 || Valid !== 1'b0 || Timeout !== 1'b0)
      $display("FAIL mid_reset got gnt=%b s=%0d v=%b to=%b want 0000 0 0 0", Gnt, S, Valid, Timeout);
    else passed++;
    Rst = 1'b0;
    Req = 4'b1111;
    step();
    total++;
    if (Gnt !== 4'b0001 || S !== 2'd0)
      $display("FAIL mid_rearb got gnt=%b s=%0d want 0001 0", Gnt, S);
    else passed++;
    Req = 4'b0000;
    step();
    step();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    Rst    = 1'b1;
    Req    = 4'b0000;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_release_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
